// File: rtl/thermo_pkg.sv
// Shared definitions for the temperature sensor reader: FSM encoding and
// frame/temperature limits.
package thermo_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    UPDATE   = 3'd4,
    ERROR    = 3'd5
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int TEMP_MAX   = 99;
  localparam int TEMP_MIN   = 0;

endpackage

// File: rtl/temp_sensor_reader_if.sv
// Bus between the temperature reader and its surroundings: SPI pins toward the
// sensor plus the request/result signals toward the host logic.
interface temp_sensor_reader_if;

  logic       sample_now;
  logic       miso;
  logic       sclk;
  logic       cs_n;
  logic [7:0] CurrentTemp;
  logic       temp_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  sample_now,
    input  miso,
    output sclk,
    output cs_n,
    output CurrentTemp,
    output temp_valid,
    output frame_err,
    output busy
  );

  modport slave (
    output sample_now,
    output miso,
    input  sclk,
    input  cs_n,
    input  CurrentTemp,
    input  temp_valid,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/spi_clk_gen.sv
// SCLK timing: half-period counter, registered sclk, rise/fall strobes and a
// bit counter that flags the falling edge closing the last bit of a frame.
module spi_clk_gen
  import thermo_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic shift_en,
  output logic sclk,
  output logic half_end,
  output logic rise,
  output logic last_fall
);

  localparam int HC_W = $clog2(CLK_DIV);
  localparam int BC_W = $clog2(FRAME_BITS);
  localparam logic [HC_W-1:0] HC_MAX  = HC_W'(CLK_DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_BITS - 1);

  logic [HC_W-1:0] half_cnt_reg;
  logic [BC_W-1:0] bit_cnt_reg;
  logic            sclk_reg;
  logic            fall;

  assign half_end  = (half_cnt_reg == HC_MAX);
  assign rise      = shift_en && half_end && !sclk_reg;
  assign fall      = shift_en && half_end && sclk_reg;
  assign last_fall = fall && (bit_cnt_reg == BC_LAST);
  assign sclk      = sclk_reg;

  // The half-period counter also times the chip-select setup and hold phases,
  // so it runs whenever the FSM is inside a frame, not only while shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      sclk_reg     <= 1'b0;
    end else if (clr) begin
      half_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      sclk_reg     <= 1'b0;
    end else begin
      half_cnt_reg <= half_end ? '0 : half_cnt_reg + 1'b1;
      if (rise) begin
        sclk_reg <= 1'b1;
      end else if (fall) begin
        sclk_reg    <= 1'b0;
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/temp_sensor_reader.sv
// Periodically reads a 16-bit SPI temperature frame, validates it, and
// publishes the clamped integer temperature (0..99 C).
module temp_sensor_reader
  import thermo_pkg::*;
#(
  parameter int CLK_DIV       = 50,
  parameter int SAMPLE_PERIOD = 1_000_000
) (
  input logic                  clk,
  input logic                  Reset,
  temp_sensor_reader_if.master bus
);

  localparam int CNT_W = $clog2(SAMPLE_PERIOD);
  localparam logic [CNT_W-1:0]  PERIOD_LAST = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic signed [8:0] T_MAX_S     = 9'(TEMP_MAX);
  localparam logic signed [8:0] T_MIN_S     = 9'(TEMP_MIN);

  state_t                  state_reg;
  logic [CNT_W-1:0]        period_cnt_reg;
  logic [FRAME_BITS-1:0]   shift_reg;
  logic                    cs_n_reg;
  logic [7:0]              cur_temp_reg;
  logic                    temp_valid_reg;
  logic                    frame_err_reg;
  logic                    busy_reg;

  logic                    period_terminal;
  logic                    start;
  logic                    gen_clr;
  logic                    shift_en;
  logic                    half_end;
  logic                    rise;
  logic                    last_fall;
  logic                    sclk_w;

  logic signed [8:0]       t_int;
  logic [7:0]              t_clamped;
  logic                    frame_ok;

  assign period_terminal = (period_cnt_reg == PERIOD_LAST);
  assign start           = (state_reg == IDLE) && (bus.sample_now || period_terminal);
  assign gen_clr         = (state_reg == IDLE) || (state_reg == UPDATE) || (state_reg == ERROR);
  assign shift_en        = (state_reg == SHIFT);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk       (clk),
    .rst       (Reset),
    .clr       (gen_clr),
    .shift_en  (shift_en),
    .sclk      (sclk_w),
    .half_end  (half_end),
    .rise      (rise),
    .last_fall (last_fall)
  );

  // Integer part is bits[15:7]; fractional bits are simply dropped.
  always_comb begin
    t_int     = signed'(shift_reg[15:7]);
    frame_ok  = (shift_reg[2:0] == 3'b000);
    t_clamped = t_int[7:0];
    if (t_int < T_MIN_S) begin
      t_clamped = 8'(TEMP_MIN);
    end else if (t_int > T_MAX_S) begin
      t_clamped = 8'(TEMP_MAX);
    end
  end

  // The period counter free-runs across frames so periodic starts stay exactly
  // SAMPLE_PERIOD apart; a sample_now start re-phases it.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_reg      <= IDLE;
      period_cnt_reg <= PERIOD_LAST;
      shift_reg      <= '0;
      cs_n_reg       <= 1'b1;
      cur_temp_reg   <= 8'd0;
      temp_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      temp_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      period_cnt_reg <= (start || period_terminal) ? '0 : period_cnt_reg + 1'b1;

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= CS_SETUP;
            cs_n_reg  <= 1'b0;
            busy_reg  <= 1'b1;
            shift_reg <= '0;
          end
        end
        CS_SETUP: begin
          if (half_end) begin
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          if (rise) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], bus.miso};
          end
          if (last_fall) begin
            state_reg <= CS_HOLD;
          end
        end
        CS_HOLD: begin
          if (half_end) begin
            cs_n_reg <= 1'b1;
            if (frame_ok) begin
              state_reg      <= UPDATE;
              cur_temp_reg   <= t_clamped;
              temp_valid_reg <= 1'b1;
            end else begin
              state_reg     <= ERROR;
              frame_err_reg <= 1'b1;
            end
          end
        end
        UPDATE, ERROR: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.sclk        = sclk_w;
  assign bus.cs_n        = cs_n_reg;
  assign bus.CurrentTemp = cur_temp_reg;
  assign bus.temp_valid  = temp_valid_reg;
  assign bus.frame_err   = frame_err_reg;
  assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Directed bench for temp_sensor_reader (CLK_DIV=2, SAMPLE_PERIOD=200) with a
// behavioural SPI sensor that shifts out sensor_word MSB first.
module tb_temp_sensor_reader;

  logic        clk   = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] sensor_word = 16'h3200;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  int   sens_idx    = 0;
  int   rise_cnt    = 0;
  int   last_rises  = 0;
  int   cs_fall_cyc = 0;
  int   valid_cnt   = 0;
  int   err_cnt     = 0;
  int   both_cnt    = 0;
  logic cs_prev     = 1'b1;
  logic sclk_prev   = 1'b0;
  logic [3:0] bit_sel;

  int ev_cyc  = 0;
  int n0      = 0;
  int start_e = 0;
  int vc      = 0;
  int ec      = 0;
  bit ok;

  temp_sensor_reader_if bus();

  temp_sensor_reader #(
    .CLK_DIV       (2),
    .SAMPLE_PERIOD (200)
  ) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign bit_sel  = 4'(15 - sens_idx);
  assign bus.miso = (sens_idx < 16) ? sensor_word[bit_sel] : 1'b0;

  // Sensor model and edge/pulse monitor, evaluated away from the active edge.
  always @(negedge clk) begin
    cs_prev   <= bus.cs_n;
    sclk_prev <= bus.sclk;
    if (cs_prev && !bus.cs_n) begin
      rise_cnt    <= 0;
      sens_idx    <= 0;
      cs_fall_cyc <= cyc;
    end else if (!bus.cs_n) begin
      if (!sclk_prev && bus.sclk) rise_cnt <= rise_cnt + 1;
      if (sclk_prev && !bus.sclk) sens_idx <= sens_idx + 1;
    end
    if (!cs_prev && bus.cs_n) last_rises <= rise_cnt;
    if (bus.temp_valid) valid_cnt <= valid_cnt + 1;
    if (bus.frame_err) err_cnt <= err_cnt + 1;
    if (bus.temp_valid && bus.frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (bus.temp_valid || bus.frame_err) begin
        seen   = 1'b1;
        ev_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic pulse_sample_now();
    @(posedge clk); #1;
    bus.sample_now = 1'b1;
    n0 = cyc;
    @(posedge clk); #1;
    bus.sample_now = 1'b0;
  endtask

  initial begin
    bus.sample_now = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n",  32'(bus.cs_n), 1);
    check("rst_sclk",  32'(bus.sclk), 0);
    check("rst_temp",  32'(bus.CurrentTemp), 0);
    check("rst_valid", 32'(bus.temp_valid), 0);
    check("rst_err",   32'(bus.frame_err), 0);
    check("rst_busy",  32'(bus.busy), 0);

    // First conversion starts on the first edge after release: 0x3200 -> 99
    Reset = 1'b0;
    @(posedge clk); #1;
    check("rel_cs_n", 32'(bus.cs_n), 0);
    check("rel_busy", 32'(bus.busy), 1);
    wait_done(100, ok);
    check("hot_done",  32'(ok), 1);
    check("hot_valid", 32'(bus.temp_valid), 1);
    check("hot_err",   32'(bus.frame_err), 0);
    check("hot_temp",  32'(bus.CurrentTemp), 99);
    check("hot_lat",   32'(ev_cyc - cs_fall_cyc), 68);
    @(posedge clk); #1;
    check("hot_pulse1", 32'(bus.temp_valid), 0);
    check("hot_busy0",  32'(bus.busy), 0);
    check("hot_rises",  32'(last_rises), 16);
    check("hot_vcnt",   32'(valid_cnt), 1);

    // sample_now with 0x0C80 -> 25, 69 cycles from request to temp_valid
    sensor_word = 16'h0C80;
    repeat (3) @(posedge clk);
    pulse_sample_now();
    check("c25_cs_n", 32'(bus.cs_n), 0);
    wait_done(100, ok);
    check("c25_done",  32'(ok), 1);
    check("c25_lat",   32'(ev_cyc - n0), 69);
    check("c25_temp",  32'(bus.CurrentTemp), 25);
    check("c25_err",   32'(bus.frame_err), 0);
    @(posedge clk); #1;
    check("c25_rises", 32'(last_rises), 16);
    check("c25_vcnt",  32'(valid_cnt), 2);

    // Bad trailer bits -> frame_err, temperature held
    sensor_word = 16'h0C81;
    repeat (3) @(posedge clk);
    pulse_sample_now();
    wait_done(100, ok);
    check("bad_done",  32'(ok), 1);
    check("bad_err",   32'(bus.frame_err), 1);
    check("bad_valid", 32'(bus.temp_valid), 0);
    check("bad_temp",  32'(bus.CurrentTemp), 25);
    @(posedge clk); #1;
    check("bad_err1",  32'(bus.frame_err), 0);
    check("bad_ecnt",  32'(err_cnt), 1);
    check("bad_vcnt",  32'(valid_cnt), 2);

    // 0xFB00 -> 0, with a sample_now during SHIFT that must be ignored
    sensor_word = 16'hFB00;
    repeat (3) @(posedge clk);
    pulse_sample_now();
    start_e = n0 + 1;
    repeat (18) @(posedge clk);
    #1;
    bus.sample_now = 1'b1;
    @(posedge clk); #1;
    bus.sample_now = 1'b0;
    wait_done(100, ok);
    check("cold_done",  32'(ok), 1);
    check("cold_temp",  32'(bus.CurrentTemp), 0);
    check("cold_start", 32'(cs_fall_cyc - start_e), 0);
    @(posedge clk); #1;
    check("cold_vcnt",  32'(valid_cnt), 3);
    check("cold_busy0", 32'(bus.busy), 0);

    // Next periodic frame starts SAMPLE_PERIOD after the previous start
    sensor_word = 16'h0C80;
    ok = 1'b0;
    for (int i = 0; i < 250; i++) begin
      @(posedge clk); #1;
      if (!bus.cs_n) begin
        ok = 1'b1;
        break;
      end
    end
    check("per_seen",  32'(ok), 1);
    check("per_start", 32'(cyc - start_e), 200);
    wait_done(100, ok);
    check("per_done",  32'(ok), 1);
    check("per_temp",  32'(bus.CurrentTemp), 25);
    @(posedge clk); #1;
    check("per_rises", 32'(last_rises), 16);

    // Reset after 5 bits of the following periodic frame
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (!bus.cs_n && rise_cnt == 5) begin
        ok = 1'b1;
        break;
      end
    end
    check("mid_seen", 32'(ok), 1);
    check("mid_sclk_hi", 32'(bus.sclk), 1);
    vc = valid_cnt;
    ec = err_cnt;
    Reset = 1'b1;
    #1;
    check("mid_cs_n", 32'(bus.cs_n), 1);
    check("mid_sclk", 32'(bus.sclk), 0);
    check("mid_temp", 32'(bus.CurrentTemp), 0);
    check("mid_busy", 32'(bus.busy), 0);
    repeat (3) @(posedge clk);
    #1;
    Reset = 1'b0;
    @(posedge clk); #1;
    check("mid_restart", 32'(bus.cs_n), 0);
    check("mid_vcnt", 32'(valid_cnt), 32'(vc));
    check("mid_ecnt", 32'(err_cnt), 32'(ec));
    wait_done(100, ok);
    check("mid_done", 32'(ok), 1);
    check("mid_temp2", 32'(bus.CurrentTemp), 25);
    @(posedge clk); #1;
    check("both_never", 32'(both_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/temp_sensor_reader.md
TEMP_SENSOR_READER -- requirements
Module: temp_sensor_reader

Interface
REQ-001 Parameter CLK_DIV, 50, clk cycles per SCLK half-period (min 2).
REQ-002 Parameter SAMPLE_PERIOD, 1_000_000, clk cycles between conversion starts (must exceed one frame length).
REQ-003 Port clk  input  1  system clock; single clock domain, all logic rising-edge.
REQ-004 Port Reset  input  1  asynchronous, active-high reset.
REQ-005 Port sample_now  input  1  one-cycle request to start a conversion immediately.
REQ-006 Port miso  input  1  serial data from the sensor, MSB first.
REQ-007 Port sclk  output  1  serial clock to the sensor, idle low.
REQ-008 Port cs_n  output  1  sensor chip select, active low.
REQ-009 Port CurrentTemp  output  8  latest valid temperature, unsigned integer degrees C, range 0..99.
REQ-010 Port temp_valid  output  1  one-cycle pulse when CurrentTemp is updated.
REQ-011 Port frame_err  output  1  one-cycle pulse when a received frame is rejected.
REQ-012 Port busy  output  1  high from conversion start until the cycle after UPDATE or ERROR.

Function
REQ-013 The FSM SHALL have the states IDLE, CS_SETUP, SHIFT, CS_HOLD, UPDATE and ERROR.
REQ-014 In IDLE, a period counter SHALL count up; a conversion SHALL start on terminal count (SAMPLE_PERIOD-1) or on sample_now, whichever occurs first, and the counter SHALL restart at 0.
REQ-015 sample_now asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-016 In CS_SETUP, cs_n SHALL be 0 and sclk SHALL be 0 for CLK_DIV cycles.
REQ-017 SHIFT SHALL generate 16 SCLK periods, each with CLK_DIV cycles low followed by CLK_DIV cycles high.
REQ-018 In SHIFT, miso SHALL be sampled into a 16-bit shift register on the clk edge where sclk rises, MSB first.
REQ-019 In CS_HOLD, sclk SHALL be 0 and cs_n SHALL be 0 for CLK_DIV cycles; cs_n SHALL then return to 1.
REQ-020 Frame format: bits[15:3] are a 13-bit two's-complement temperature in 1/16 degree C steps, and bits[2:0] SHALL equal 000.
REQ-021 If bits[2:0]≠000, the FSM SHALL enter ERROR for one cycle, pulse frame_err, and leave CurrentTemp unchanged.
REQ-022 Conversion SHALL truncate the temperature to an integer, t = bits[15:7] signed; if t<0 the result SHALL be 0, if t>99 it SHALL be 99, otherwise t.
REQ-023 In UPDATE (one cycle), CurrentTemp SHALL be loaded and temp_valid SHALL pulse in the same cycle.
REQ-024 From the start condition to the temp_valid cycle SHALL take exactly CLK_DIV + 32*CLK_DIV + CLK_DIV + 1 cycles; with CLK_DIV=2 this is 69.
REQ-025 The FSM SHALL return to IDLE after UPDATE or ERROR; temp_valid and frame_err SHALL never be high together.
REQ-026 All outputs SHALL be registered, with no glitches on sclk or cs_n.

Reset
REQ-027 Reset SHALL force, asynchronously: state IDLE, cs_n=1, sclk=0, CurrentTemp=0, temp_valid=0, frame_err=0, busy=0, shift register 0.
REQ-028 Reset mid-frame SHALL abort the transfer with no output pulse.
REQ-029 The period counter SHALL reset to SAMPLE_PERIOD-1, so the first conversion starts on the first clk edge after Reset deasserts.

Structure
REQ-030 The shared package thermo_pkg SHALL hold the FSM state encoding, FRAME_BITS=16, TEMP_MAX=99 and TEMP_MIN=0.
REQ-031 SCLK timing SHALL be produced by one sub-module, spi_clk_gen (half-period counter, rise/fall strobes, bit counter).
REQ-032 Clamp and convert logic SHALL be combinational inside temp_sensor_reader.

Verification (CLK_DIV=2, SAMPLE_PERIOD=200)
REQ-033 Sensor model drives 0x0C80 after sample_now -> temp_valid 69 cycles later, CurrentTemp=25, frame_err=0.
REQ-034 Frame 0x3200 (100.0 C) -> CurrentTemp=99; frame 0xFB00 (-10.0 C) -> CurrentTemp=0; each with one temp_valid pulse.
REQ-035 Frame 0x0C81 following a 25 result -> frame_err pulses once, temp_valid stays 0, CurrentTemp holds 25.
REQ-036 Reset asserted after 5 bits have shifted -> cs_n=1, sclk=0, CurrentTemp=0 immediately; a new conversion starts on the first edge after release.
REQ-037 sample_now pulsed during SHIFT -> ignored; the next frame starts 200 cycles after the previous start; the bench checks exactly 16 sclk rising edges per cs_n-low window.
